// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam int MD_LAT_DEF = 4;
  localparam int CNT_W      = 4;
  localparam int PERF_W     = 32;

endpackage

// File: rtl/md_timer.sv
// Loadable down-counter that times the EX residency of a multi-cycle mul/div.
module md_timer
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, mul/div stall.
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead_EX,
  input  logic [4:0]  rd_EX,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        useRs1_ID,
  input  logic        useRs2_ID,
  input  logic        branchTaken_EX,
  input  logic        mdStart_EX,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        idexWrite,
  output logic        ifidFlush,
  output logic        idexFlush,
  output logic        exmemBubble,
  output logic        mdDone,
`ifdef HAZARD_CTRL_PERF_EN
  output logic [PERF_W-1:0] stallCycles,
  output logic [PERF_W-1:0] flushCount,
`endif
  output state_e      dbgState
);

  localparam logic [CNT_W-1:0] MD_RELOAD = CNT_W'(MD_LAT - 2);

  state_e state_q, state_d;
  logic   md_load, md_dec, md_zero;
  logic   load_use;

  md_timer u_md_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (md_load),
    .dec_i      (md_dec),
    .load_val_i (MD_RELOAD),
    .zero_o     (md_zero)
  );

  assign load_use = memRead_EX && (rd_EX != 5'd0) &&
                    ((useRs1_ID && (rs1_ID == rd_EX)) ||
                     (useRs2_ID && (rs2_ID == rd_EX)));

  // Priority in RUN: taken branch, then mul/div start, then load-use.
  // Reset forces the idle outputs even while it is held.
  always_comb begin
    state_d     = state_q;
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    idexWrite   = 1'b1;
    ifidFlush   = 1'b0;
    idexFlush   = 1'b0;
    exmemBubble = 1'b0;
    mdDone      = 1'b0;
    md_load     = 1'b0;
    md_dec      = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (branchTaken_EX) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
          end else if (mdStart_EX) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            exmemBubble = 1'b1;
            md_load     = 1'b1;
            state_d     = MD_WAIT;
          end else if (load_use) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
          end
        end
        MD_WAIT: begin
          if (!md_zero) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            exmemBubble = 1'b1;
            md_dec      = 1'b1;
          end else begin
            mdDone  = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign dbgState = state_q;

`ifdef HAZARD_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_q, flush_q;

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pcWrite && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (ifidFlush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stallCycles = stall_q;
  assign flushCount  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared against a residency-count reference model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MD_LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       memRead_EX = 1'b0;
  logic [4:0] rd_EX = '0, rs1_ID = '0, rs2_ID = '0;
  logic       useRs1_ID = 1'b0, useRs2_ID = 1'b0;
  logic       branchTaken_EX = 1'b0, mdStart_EX = 1'b0;
  logic       pcWrite, ifidWrite, idexWrite, ifidFlush, idexFlush, exmemBubble, mdDone;
  state_e     dbg_state;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stallCycles, flushCount;
`endif

  hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .memRead_EX     (memRead_EX),
    .rd_EX          (rd_EX),
    .rs1_ID         (rs1_ID),
    .rs2_ID         (rs2_ID),
    .useRs1_ID      (useRs1_ID),
    .useRs2_ID      (useRs2_ID),
    .branchTaken_EX (branchTaken_EX),
    .mdStart_EX     (mdStart_EX),
    .pcWrite        (pcWrite),
    .ifidWrite      (ifidWrite),
    .idexWrite      (idexWrite),
    .ifidFlush      (ifidFlush),
    .idexFlush      (idexFlush),
    .exmemBubble    (exmemBubble),
    .mdDone         (mdDone),
`ifdef HAZARD_CTRL_PERF_EN
    .stallCycles    (stallCycles),
    .flushCount     (flushCount),
`endif
    .dbgState       (dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];

  // Model state: cycles of EX residency still owed by an in-flight mul/div.
  int md_left = 0;
  longint exp_stall = 0;
  longint exp_flush = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output vector order: pcWrite ifidWrite idexWrite ifidFlush idexFlush exmemBubble mdDone
  task automatic step(input logic r, input logic mr, input logic [4:0] rd,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic u1, input logic u2, input logic br, input logic md);
    logic [6:0] e;
    logic       lu;
    logic       busy;
    @(posedge clk);
    #1;
    rst = r; memRead_EX = mr; rd_EX = rd; rs1_ID = s1; rs2_ID = s2;
    useRs1_ID = u1; useRs2_ID = u2; branchTaken_EX = br; mdStart_EX = md;

    e    = 7'b1110000;
    lu   = mr && (rd != 0) && ((u1 && s1 == rd) || (u2 && s2 == rd));
    busy = (md_left != 0);
    if (r) begin
      md_left = 0;
      busy = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
    end else if (!busy) begin
      if (br) e = 7'b1111100;
      else if (md) begin
        e = 7'b0000010;
        md_left = MD_LAT - 1;
      end else if (lu) e = 7'b0010100;
    end else if (md_left > 1) begin
      e = 7'b0000010;
      md_left--;
    end else begin
      e = 7'b1110001;
      md_left = 0;
    end
    exp_q.push_back(e);

    #3;
    check("outputs", 32'({pcWrite, ifidWrite, idexWrite, ifidFlush, idexFlush, exmemBubble, mdDone}),
          32'(exp_q.pop_front()));
    check("state", 32'(dbg_state == MD_WAIT), 32'(busy));
`ifdef HAZARD_CTRL_PERF_EN
    check("stallCycles", stallCycles, 32'(exp_stall));
    check("flushCount", flushCount, 32'(exp_flush));
`endif
    if (!r) begin
      if (!e[6] && exp_stall < 64'hFFFF_FFFF) exp_stall++;
      if (e[3] && exp_flush < 64'hFFFF_FFFF) exp_flush++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset held with noisy inputs must still show idle outputs.
    step(1, 1, 5, 5, 5, 1, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Back-to-back mul/div held, then taken branch with a load-use pending.
    for (int i = 0; i < MD_LAT; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 5, 0, 5, 0, 1, 1, 0);
    idle(1);

    // Single-cycle load-use on rs2, then rd=0 which must not stall.
    step(0, 1, 5, 0, 5, 0, 1, 0, 0);
    idle(1);
    step(0, 1, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 7, 7, 3, 1, 0, 0, 0);
    step(0, 1, 7, 7, 3, 0, 1, 0, 0);

    // Reset in the second MD_WAIT cycle, then a full sequence again.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(MD_LAT);

    // Inputs in MD_WAIT are ignored.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 3, 3, 3, 1, 1, 1, 1);
    step(0, 1, 3, 3, 3, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99) == 0,
           1'($urandom),
           5'($urandom_range(7)),
           5'($urandom_range(7)),
           5'($urandom_range(7)),
           1'($urandom),
           1'($urandom),
           $urandom_range(5) == 0,
           $urandom_range(7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
